// File: rtl/double_to_sint_if.sv
// double_to_sint_if
// Handshake/data bundle shared by the double-to-int converter and its user.
//   en        : block enable (master -> converter)
//   input_a   : IEEE-754 double operand (master -> converter)
//   output_z  : signed 32-bit result (converter -> master)
//   complete  : one-cycle result-valid pulse (converter -> master)
//   invalid   : NaN / Inf / out-of-range flag, held with output_z
interface double_to_sint_if;
    logic        en;
    logic [63:0] input_a;
    logic [31:0] output_z;
    logic        complete;
    logic        invalid;

    modport master (
        output en,
        output input_a,
        input  output_z,
        input  complete,
        input  invalid
    );

    modport slave (
        input  en,
        input  input_a,
        output output_z,
        output complete,
        output invalid
    );
endinterface

// File: rtl/double_to_sint.sv
// double_to_sint
// Converts an IEEE-754 double to a signed 32-bit integer, rounding toward
// zero and saturating out-of-range inputs. Iterative FSM: the mantissa is
// shifted right one bit per cycle until the binary point sits at bit 0.
// Free-running while en is high; each result is announced by a one-cycle
// complete pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : double_to_sint_if.slave (en, input_a, output_z, complete, invalid)
// Parameters:
//   NAN_VALUE : integer result returned for any NaN operand
module double_to_sint #(
    parameter logic [31:0] NAN_VALUE = 32'h80000000
) (
    input  logic             clk,
    input  logic             rst,
    double_to_sint_if.slave  bus
);

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        SPECIAL,
        SHIFT,
        SIGN,
        PUT_Z
    } state_t;

    state_t             state;
    logic [63:0]        a;
    logic               s;
    logic [10:0]        be;
    logic [51:0]        f;
    logic [52:0]        m;
    logic signed [11:0] e;
    logic [31:0]        z;
    logic               inv;

    // en low behaves like reset: it aborts any conversion in flight and
    // clears the visible outputs, so no stale completion ever escapes.
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            state        <= GET_A;
            bus.output_z <= 32'd0;
            bus.complete <= 1'b0;
            bus.invalid  <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    a            <= bus.input_a;
                    bus.complete <= 1'b0;
                    state        <= UNPACK;
                end

                UNPACK: begin
                    s     <= a[63];
                    be    <= a[62:52];
                    f     <= a[51:0];
                    m     <= {1'b1, a[51:0]};
                    e     <= $signed({1'b0, a[62:52]}) - 12'sd1023;
                    state <= SPECIAL;
                end

                // Rule order matters: NaN/Inf first, then |x| < 1, then the
                // single in-range value with e = 31 (-2^31), then saturation.
                SPECIAL: begin
                    if (be == 11'h7FF && f != 52'd0) begin
                        z     <= NAN_VALUE;
                        inv   <= 1'b1;
                        state <= PUT_Z;
                    end else if (be == 11'h7FF) begin
                        z     <= s ? 32'h80000000 : 32'h7FFFFFFF;
                        inv   <= 1'b1;
                        state <= PUT_Z;
                    end else if (be < 11'd1023) begin
                        z     <= 32'd0;
                        inv   <= 1'b0;
                        state <= PUT_Z;
                    end else if (e == 12'sd31 && s && f == 52'd0) begin
                        z     <= 32'h80000000;
                        inv   <= 1'b0;
                        state <= PUT_Z;
                    end else if (e >= 12'sd31) begin
                        z     <= s ? 32'h80000000 : 32'h7FFFFFFF;
                        inv   <= 1'b1;
                        state <= PUT_Z;
                    end else begin
                        inv   <= 1'b0;
                        state <= SHIFT;
                    end
                end

                // Shifted-out fraction bits are simply dropped, which is
                // exactly truncation toward zero on the magnitude.
                SHIFT: begin
                    if (e < 12'sd52) begin
                        m <= m >> 1;
                        e <= e + 12'sd1;
                    end else begin
                        state <= SIGN;
                    end
                end

                // With e <= 30 on entry the magnitude is below 2^31, so the
                // low 32 bits hold it completely.
                SIGN: begin
                    z     <= s ? (32'd0 - m[31:0]) : m[31:0];
                    state <= PUT_Z;
                end

                PUT_Z: begin
                    bus.output_z <= z;
                    bus.invalid  <= inv;
                    bus.complete <= 1'b1;
                    state        <= GET_A;
                end

                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule
